// File: rtl/wb_mtimer.sv
// wb_mtimer: RISC-V machine timer (mtime/mtimecmp, prescaler, level irq) behind a Wishbone slave.
// Latency: ack and read data one cycle after each request; irq_timer one cycle after a compare change.
// Backpressure: none, stall is tied low and every request (including unmapped offsets) is acked.
module wb_mtimer #(
  parameter logic [15:0] PRESCALE_RESET = 16'd0,
  parameter logic        ENABLE_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_m,
  output logic [31:0] wb_dat_s,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        wb_err,
  output logic        irq_timer
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow_hi;
  logic [15:0] r_cnt;
  logic [15:0] r_prescale;
  logic        r_en;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_irq;

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_idx;
  logic        w_tick;
  logic [31:0] w_ctrl;
  logic [31:0] w_ctrl_new;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte-lane merge: selected lanes take the bus data, the rest keep the old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_req      = wb_cyc & wb_stb;
  assign w_wr       = w_req & wb_we;
  assign w_rd       = w_req & ~wb_we;
  assign w_idx      = wb_adr[4:2];
  assign w_tick     = r_en && (r_cnt == r_prescale);
  assign w_ctrl     = {r_prescale, 15'd0, r_en};
  assign w_ctrl_new = lane_merge(w_ctrl, wb_dat_m, wb_sel);
  assign w_unused   = ^{wb_adr[31:5], wb_adr[1:0], w_ctrl_new[15:1]};

  // Read mux over current register values; HI returns the snapshot taken by the last LO read.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      A_MTIME_LO: w_rdata = r_mtime[31:0];
      A_MTIME_HI: w_rdata = r_shadow_hi;
      A_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      A_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      A_CTRL:     w_rdata = w_ctrl;
      default:    w_rdata = 32'd0;
    endcase
  end

  // Bus response: ack one cycle after each request, data only on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Control register and prescale counter; any CTRL write restarts the tick phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= ENABLE_RESET;
      r_prescale <= PRESCALE_RESET;
      r_cnt      <= 16'd0;
    end else begin
      if (w_wr && w_idx == A_CTRL) begin
        r_en       <= w_ctrl_new[0];
        r_prescale <= w_ctrl_new[31:16];
        r_cnt      <= 16'd0;
      end else if (r_en) begin
        r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
      end
    end
  end

  // mtime: a bus write to either half suppresses that cycle's tick entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= 64'd0;
    end else if (w_wr && w_idx == A_MTIME_LO) begin
      r_mtime <= {r_mtime[63:32], lane_merge(r_mtime[31:0], wb_dat_m, wb_sel)};
    end else if (w_wr && w_idx == A_MTIME_HI) begin
      r_mtime <= {lane_merge(r_mtime[63:32], wb_dat_m, wb_sel), r_mtime[31:0]};
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp writes and the coherent-read snapshot of mtime[63:32].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_shadow_hi <= 32'd0;
    end else begin
      if (w_wr && w_idx == A_CMP_LO)
        r_mtimecmp[31:0] <= lane_merge(r_mtimecmp[31:0], wb_dat_m, wb_sel);
      if (w_wr && w_idx == A_CMP_HI)
        r_mtimecmp[63:32] <= lane_merge(r_mtimecmp[63:32], wb_dat_m, wb_sel);
      if (w_rd && w_idx == A_MTIME_LO)
        r_shadow_hi <= r_mtime[63:32];
    end
  end

  // Level interrupt from a registered unsigned compare, independent of EN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (r_mtime >= r_mtimecmp);
  end

  assign wb_ack    = r_ack;
  assign wb_dat_s  = r_dat;
  assign wb_stall  = 1'b0;
  assign wb_err    = 1'b0;
  assign irq_timer = r_irq;

endmodule

// File: tb/tb_wb_mtimer.sv
// tb_wb_mtimer: scenario tasks driving wb_mtimer against a tick-count reference model.
// Latency: each step is one clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: the DUT never stalls, so every step that requests expects an ack.
module tb_wb_mtimer;

  logic        clk;
  logic        rst;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_m;
  logic [31:0] wb_dat_s;
  logic        wb_ack;
  logic        wb_stall;
  logic        wb_err;
  logic        irq_timer;

  int total = 0;
  int bad   = 0;

  // Reference model: mtime advances once per (PRESCALE+1) enabled cycles counted from the
  // last CTRL write or reset; m_k is the number of enabled cycles in the current phase.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic        m_en;
  logic [15:0] m_pre;
  longint      m_k;

  logic        exp_ack, exp_irq, got_ack, got_irq;
  logic [31:0] exp_dat, got_dat;

  wb_mtimer dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err), .irq_timer(irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bytes_in(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_shadow = 32'd0;
    m_en     = 1'b1;
    m_pre    = 16'd0;
    m_k      = 0;
  endtask

  // One bus cycle: drive, predict, clock, sample.
  task automatic step(input logic cyc, input logic stb, input logic we, input logic [2:0] idx,
                      input logic [3:0] sel, input logic [31:0] dat);
    logic        req, tick;
    logic [31:0] c;
    wb_cyc = cyc; wb_stb = stb; wb_we = we;
    wb_adr = {27'd0, idx, 2'b00}; wb_sel = sel; wb_dat_m = dat;
    req     = cyc & stb;
    exp_ack = req;
    exp_irq = (m_mtime >= m_cmp);
    exp_dat = 32'd0;
    if (req && !we) begin
      case (idx)
        3'd0: exp_dat = m_mtime[31:0];
        3'd1: exp_dat = m_shadow;
        3'd2: exp_dat = m_cmp[31:0];
        3'd3: exp_dat = m_cmp[63:32];
        3'd4: exp_dat = {m_pre, 15'd0, m_en};
        default: exp_dat = 32'd0;
      endcase
    end
    tick = m_en && ((m_k % (longint'(m_pre) + 1)) == longint'(m_pre));
    if (m_en) m_k++;
    if (req && !we && idx == 3'd0) m_shadow = m_mtime[63:32];
    if (tick && !(req && we && idx < 3'd2)) m_mtime = m_mtime + 64'd1;
    if (req && we) begin
      case (idx)
        3'd0: m_mtime[31:0]  = bytes_in(m_mtime[31:0], dat, sel);
        3'd1: m_mtime[63:32] = bytes_in(m_mtime[63:32], dat, sel);
        3'd2: m_cmp[31:0]    = bytes_in(m_cmp[31:0], dat, sel);
        3'd3: m_cmp[63:32]   = bytes_in(m_cmp[63:32], dat, sel);
        3'd4: begin
          c     = bytes_in({m_pre, 15'd0, m_en}, dat, sel);
          m_en  = c[0];
          m_pre = c[31:16];
          m_k   = 0;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    got_ack = wb_ack; got_dat = wb_dat_s; got_irq = irq_timer;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_sel = 0; wb_dat_m = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (wb_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", wb_ack); end
    total++; if (wb_dat_s !== 32'd0) begin bad++; $display("FAIL rst_dat got=%h exp=0", wb_dat_s); end
    total++; if (irq_timer !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_timer); end
    model_reset();
    rst = 1'b0;
    idle(1);
    total++; if (got_ack !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b exp=0", got_ack); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'(i), 4'hF, 32'd0);
      total++; if (got_ack !== 1'b1) begin bad++; $display("FAIL reset_rd_ack[%0d] got=%b exp=1", i, got_ack); end
      total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL reset_rd[%0d] got=%h exp=%h", i, got_dat, exp_dat); end
      total++; if (got_irq !== 1'b0) begin bad++; $display("FAIL reset_irq[%0d] got=%b exp=0", i, got_irq); end
      idle(1);
      total++; if (got_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_drop[%0d] got=%b exp=0", i, got_ack); end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] first;
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0063_0001);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd1, 4'hF, 32'd0);
    idle(1000);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL presc_lo got=%0d exp=%0d", got_dat, exp_dat); end
    total++; if (got_dat < 32'd9 || got_dat > 32'd11) begin bad++; $display("FAIL presc_range got=%0d exp=9..11", got_dat); end
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    first = got_dat;
    total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL frozen_a got=%h exp=%h", got_dat, exp_dat); end
    idle(200);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== first) begin bad++; $display("FAIL frozen_b got=%h exp=%h", got_dat, first); end
    for (int it = 0; it < 5; it++) begin
      step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, {16'($urandom_range(0, 7)), 16'h0001});
      idle(int'($urandom_range(0, 40)));
      step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
      total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL rnd_presc_lo[%0d] got=%h exp=%h", it, got_dat, exp_dat); end
      step(1'b1, 1'b1, 1'b0, 3'd1, 4'hF, 32'd0);
      total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL rnd_presc_hi[%0d] got=%h exp=%h", it, got_dat, exp_dat); end
    end
  endtask

  task automatic test_irq();
    logic [63:0] pre;
    bit rise;
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd1, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd3, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 4'hF, 32'd50);
    rise = 0;
    for (int i = 0; i < 120 && !rise; i++) begin
      pre = m_mtime;
      idle(1);
      total++; if (got_irq !== exp_irq) begin bad++; $display("FAIL irq_track[%0d] got=%b exp=%b", i, got_irq, exp_irq); end
      if (got_irq === 1'b1) begin
        rise = 1;
        total++; if (pre !== 64'd50) begin bad++; $display("FAIL irq_rise_at got=%0d exp=50", pre); end
      end
    end
    if (!rise) begin total++; bad++; $display("FAIL irq_rise_timeout got=0 exp=1"); end
    idle(5);
    total++; if (got_irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", got_irq); end
    step(1'b1, 1'b1, 1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF);
    total++; if (got_irq !== exp_irq) begin bad++; $display("FAIL irq_fall got=%b exp=%b", got_irq, exp_irq); end
    idle(1);
    total++; if (got_irq !== 1'b0) begin bad++; $display("FAIL irq_low got=%b exp=0", got_irq); end
  endtask

  task automatic test_carry();
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE);
    step(1'b1, 1'b1, 1'b1, 3'd1, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== 32'h0000_0001) begin bad++; $display("FAIL carry_lo got=%h exp=00000001", got_dat); end
    step(1'b1, 1'b1, 1'b0, 3'd1, 4'hF, 32'd0);
    total++; if (got_dat !== 32'h0000_0001) begin bad++; $display("FAIL carry_hi got=%h exp=00000001", got_dat); end
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b1, 3'd1, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== 32'hFFFF_FFFF) begin bad++; $display("FAIL precarry_lo got=%h exp=ffffffff", got_dat); end
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 3'd1, 4'hF, 32'd0);
    total++; if (got_dat !== 32'd0) begin bad++; $display("FAIL shadow_hi got=%h exp=00000000", got_dat); end
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd1, 4'hF, 32'd0);
    total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL postcarry_hi got=%h exp=%h", got_dat, exp_dat); end
  endtask

  task automatic test_collision();
    logic [2:0] idx;
    logic       we;
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'hAAAA_0000);
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'b0011, 32'h1234_5678);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== 32'hAAAA_5678) begin bad++; $display("FAIL lane_write got=%h exp=aaaa5678", got_dat); end
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0);
    total++; if (got_dat !== 32'hAAAA_5679) begin bad++; $display("FAIL lane_next got=%h exp=aaaa5679", got_dat); end
    for (int i = 0; i < 40; i++) begin
      idx = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      step(1'b1, 1'b1, we, idx, 4'($urandom), $urandom);
      total++; if (got_ack !== 1'b1 || got_dat !== exp_dat || got_irq !== exp_irq) begin
        bad++;
        $display("FAIL rnd_op[%0d] idx=%0d we=%b got=%b/%h/%b exp=1/%h/%b", i, idx, we,
                 got_ack, got_dat, got_irq, exp_dat, exp_irq);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'(2 * i), 4'hF, 32'd0);
      total++; if (got_ack !== 1'b1 || wb_stall !== 1'b0 || wb_err !== 1'b0) begin
        bad++; $display("FAIL b2b_hs[%0d] got=%b%b%b exp=100", i, got_ack, wb_stall, wb_err);
      end
      total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL b2b_dat[%0d] got=%h exp=%h", i, got_dat, exp_dat); end
    end
    total++; if (got_dat !== 32'd0) begin bad++; $display("FAIL unmapped got=%h exp=0", got_dat); end
    step(1'b0, 1'b1, 1'b1, 3'd2, 4'hF, 32'h0000_0005);
    total++; if (got_ack !== 1'b0) begin bad++; $display("FAIL nocyc_ack got=%b exp=0", got_ack); end
    step(1'b1, 1'b1, 1'b0, 3'd2, 4'hF, 32'd0);
    total++; if (got_dat !== exp_dat) begin bad++; $display("FAIL nocyc_ignored got=%h exp=%h", got_dat, exp_dat); end
    // Outstanding ack plus a write presented but not yet clocked, then reset.
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h8; wb_sel = 4'hF; wb_dat_m = 32'h1234;
    #2 rst = 1'b1;
    #1;
    total++; if (wb_ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0", wb_ack); end
    @(posedge clk);
    #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    model_reset();
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 3'd2, 4'hF, 32'd0);
    total++; if (got_dat !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_write_lost got=%h exp=ffffffff", got_dat); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_irq();
    test_carry();
    test_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
